approx_mult_err_accum: RTL and testbench

Downstream error-characterisation stage for the 8x8 approximate multipliers. It accepts a stream of operand pairs together with the approximate product the multiplier produced, and recomputes the exact product in a registered pipeline. Over a programmed window of samples it accumulates the sum of absolute errors, the maximum absolute error and the count of erroneous samples, then presents the statistics through a valid/ready result port. It sits directly after the approximate multiplier in the evaluation datapath and is used for on-FPGA MED/ER measurement.

---
 rtl/approx_mult_pkg.sv | 32 +++
 rtl/err_abs_diff.sv | 21 ++
 rtl/approx_mult_err_accum.sv | 175 +++++++++++++++++
 tb/tb_approx_mult_err_accum.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mult_pkg.sv
// Shared definitions for the approximate-multiplier error monitors:
// FSM state encoding, default widths and a saturating adder.
package approx_mult_pkg;

   localparam int unsigned DEF_WIDTH = 8;
   localparam int unsigned DEF_CNT_W = 16;
   localparam int unsigned DEF_ACC_W = 40;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Adds inc to acc and clamps the result at the all-ones value of a
   // w-bit accumulator (w <= 64). Callers narrow the result back to w bits.
   function automatic logic [63:0] sat_add(input logic [63:0] acc,
                                           input logic [63:0] inc,
                                           input int unsigned w);
      logic [64:0] sum;
      logic [64:0] lim;
      sum = {1'b0, acc} + {1'b0, inc};
      lim = (65'd1 << w) - 65'd1;
      if (sum > lim) begin
         return lim[63:0];
      end else begin
         return sum[63:0];
      end
   endfunction

endpackage

// File: rtl/err_abs_diff.sv
// Combinational absolute difference |x - y| of two unsigned values.
// Shared by the error monitors that follow the approximate multipliers.
module err_abs_diff #(
   parameter int unsigned W = 16
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   output logic [W-1:0] d
);

   // Subtract the smaller operand from the larger so the result never wraps.
   always_comb begin
      d = '0;
      if (x >= y) begin
         d = x - y;
      end else begin
         d = y - x;
      end
   end

endmodule

// File: rtl/approx_mult_err_accum.sv
// Error-characterisation stage for an approximate multiplier. Over a window
// of num_samples beats it recomputes the exact product, and accumulates the
// saturating sum of absolute errors, the maximum error and the count of
// erroneous samples. Results are offered on a valid/ready port.
// Pipeline: accept edge T registers the exact product, T+1 registers the
// absolute error, T+2 updates the accumulators.
module approx_mult_err_accum
   import approx_mult_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned CNT_W = DEF_CNT_W,
   parameter int unsigned ACC_W = DEF_ACC_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [CNT_W-1:0]         num_samples,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_a,
   input  logic [WIDTH-1:0]         in_b,
   input  logic [WIDTH+WIDTH-1:0]   in_r,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ACC_W-1:0]         sum_abs_err,
   output logic [WIDTH+WIDTH-1:0]   max_abs_err,
   output logic [CNT_W-1:0]         err_count,
   output logic                     busy
);

   localparam int unsigned PW = WIDTH + WIDTH;

   state_t           state_r;
   state_t           state_nx_s;
   logic [CNT_W-1:0] num_r;
   logic [CNT_W-1:0] acc_cnt_r;
   logic             accept_s;
   logic             last_s;
   logic             start_go_s;
   logic [PW-1:0]    exact_s;
   logic             s1_valid_r;
   logic [PW-1:0]    s1_exact_r;
   logic [PW-1:0]    s1_r_r;
   logic [PW-1:0]    diff_s;
   logic             s2_valid_r;
   logic [PW-1:0]    s2_d_r;
   logic [ACC_W-1:0] sum_nx_s;

   // in_ready is registered high exactly while in RUN, so it doubles as the RUN qualifier.
   assign accept_s   = in_valid && in_ready;
   assign last_s     = accept_s && (acc_cnt_r == (num_r - CNT_W'(1)));
   assign start_go_s = (state_r == ST_IDLE) && start;
   assign exact_s    = {{WIDTH{1'b0}}, in_a} * {{WIDTH{1'b0}}, in_b};
   assign sum_nx_s   = ACC_W'(sat_add(64'(sum_abs_err), 64'(s2_d_r), ACC_W));

   err_abs_diff #(.W(PW)) u_abs_diff (
      .x (s1_exact_r),
      .y (s1_r_r),
      .d (diff_s)
   );

   // Next-state logic for the window FSM.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_nx_s = (num_samples != '0) ? ST_RUN : ST_DONE;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (last_s) begin
               state_nx_s = ST_DRAIN;
            end else begin
               state_nx_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (!s1_valid_r && !s2_valid_r) begin
               state_nx_s = ST_DONE;
            end else begin
               state_nx_s = ST_DRAIN;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_DONE;
            end
         end
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // State register and handshake flags, registered from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state_r   <= state_nx_s;
         in_ready  <= (state_nx_s == ST_RUN);
         out_valid <= (state_nx_s == ST_DONE);
         busy      <= (state_nx_s != ST_IDLE);
      end
   end

   // Window length latch and accepted-beat counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         num_r     <= '0;
         acc_cnt_r <= '0;
      end else if (start_go_s) begin
         num_r     <= num_samples;
         acc_cnt_r <= '0;
      end else if (accept_s) begin
         acc_cnt_r <= acc_cnt_r + CNT_W'(1);
      end
   end

   // Stage 1: exact product and the approximate product it is compared with.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         s1_exact_r <= '0;
         s1_r_r     <= '0;
      end else begin
         s1_valid_r <= accept_s;
         if (accept_s) begin
            s1_exact_r <= exact_s;
            s1_r_r     <= in_r;
         end
      end
   end

   // Stage 2: registered absolute error, keeps the wide add off the diff path.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid_r <= 1'b0;
         s2_d_r     <= '0;
      end else begin
         s2_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            s2_d_r <= diff_s;
         end
      end
   end

   // Statistics accumulators; cleared on an accepted start, held otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_abs_err <= '0;
         max_abs_err <= '0;
         err_count   <= '0;
      end else if (start_go_s) begin
         sum_abs_err <= '0;
         max_abs_err <= '0;
         err_count   <= '0;
      end else if (s2_valid_r) begin
         sum_abs_err <= sum_nx_s;
         if (s2_d_r > max_abs_err) begin
            max_abs_err <= s2_d_r;
         end
         if (s2_d_r != '0) begin
            err_count <= err_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_approx_mult_err_accum.sv
// Self-checking bench for approx_mult_err_accum. Two instances share all
// inputs: the default 40-bit accumulator and an 8-bit one for saturation.
module tb_approx_mult_err_accum;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] num_samples;
   logic        in_valid;
   logic [7:0]  in_a;
   logic [7:0]  in_b;
   logic [15:0] in_r;
   logic        out_ready;

   logic        in_ready, out_valid, busy;
   logic [39:0] sum_abs_err;
   logic [15:0] max_abs_err, err_count;
   logic        in_ready8, out_valid8, busy8;
   logic [7:0]  sum8;
   logic [15:0] max8, cnt8;

   typedef struct {
      logic [39:0] sum;
      logic [7:0]  sum8;
      logic [15:0] mx;
      logic [15:0] cnt;
   } stat_t;

   stat_t       exp_q[$];
   stat_t       last_exp;
   logic [7:0]  qa[$];
   logic [7:0]  qb[$];
   logic [15:0] qr[$];
   int          passed = 0;
   int          total = 0;

   approx_mult_err_accum dut (
      .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .in_r(in_r), .out_valid(out_valid), .out_ready(out_ready),
      .sum_abs_err(sum_abs_err), .max_abs_err(max_abs_err),
      .err_count(err_count), .busy(busy)
   );

   approx_mult_err_accum #(.ACC_W(8)) dut8 (
      .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
      .in_valid(in_valid), .in_ready(in_ready8), .in_a(in_a), .in_b(in_b),
      .in_r(in_r), .out_valid(out_valid8), .out_ready(out_ready),
      .sum_abs_err(sum8), .max_abs_err(max8),
      .err_count(cnt8), .busy(busy8)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_beats;
      qa.delete();
      qb.delete();
      qr.delete();
   endtask

   task automatic add_beat(input logic [7:0] a, input logic [7:0] b, input logic [15:0] r);
      qa.push_back(a);
      qb.push_back(b);
      qr.push_back(r);
   endtask

   // Reference model: statistics over the first n queued beats.
   task automatic push_expected(input int n);
      stat_t e;
      longint unsigned ex, d, s40, s8;
      e.mx = 16'd0;
      e.cnt = 16'd0;
      s40 = 64'd0;
      s8 = 64'd0;
      for (int i = 0; i < n; i++) begin
         ex = 64'(qa[i]) * 64'(qb[i]);
         if (ex >= 64'(qr[i])) d = ex - 64'(qr[i]);
         else d = 64'(qr[i]) - ex;
         s40 = s40 + d;
         if (s40 > 64'hFF_FFFF_FFFF) s40 = 64'hFF_FFFF_FFFF;
         s8 = s8 + d;
         if (s8 > 64'd255) s8 = 64'd255;
         if (d > 64'(e.mx)) e.mx = d[15:0];
         if (d != 64'd0) e.cnt = e.cnt + 16'd1;
      end
      e.sum = s40[39:0];
      e.sum8 = s8[7:0];
      exp_q.push_back(e);
   endtask

   // Start a window, stream `cycles` cycles of in_valid, then check results.
   task automatic run_window(input int n, input int cycles, input string tag);
      int accepted = 0;
      int since = 0;
      int waited = 0;
      bit acc;
      bit gap = 1'b0;
      stat_t e;
      push_expected(n);
      num_samples = 16'(n);
      start = 1'b1;
      tick;
      start = 1'b0;
      num_samples = 16'd0;
      total++;
      if (n == 0) begin
         if (out_valid !== 1'b1) $display("FAIL %s zero_valid: got %b expected 1", tag, out_valid);
         else passed++;
      end else begin
         if (in_ready !== 1'b1) $display("FAIL %s ready_after_start: got %b expected 1", tag, in_ready);
         else passed++;
      end
      for (int c = 0; c < cycles; c++) begin
         in_valid = 1'b1;
         in_a = qa[c];
         in_b = qb[c];
         in_r = qr[c];
         acc = in_ready;
         if (accepted < n && in_ready !== 1'b1) gap = 1'b1;
         tick;
         if (acc) begin
            accepted++;
            since = 0;
            if (accepted == n) begin
               total++;
               if (in_ready !== 1'b0) $display("FAIL %s ready_after_last: got %b expected 0", tag, in_ready);
               else passed++;
            end
         end else begin
            since++;
         end
      end
      in_valid = 1'b0;
      while (out_valid !== 1'b1 && waited < 50) begin
         tick;
         since++;
         waited++;
      end
      total++;
      if (out_valid !== 1'b1) $display("FAIL %s out_valid_timeout: got %b expected 1", tag, out_valid);
      else passed++;
      total++;
      if (accepted != n) $display("FAIL %s accepted: got %0d expected %0d", tag, accepted, n);
      else passed++;
      if (n > 0) begin
         total++;
         if (since != 3) $display("FAIL %s latency: got %0d expected 3", tag, since);
         else passed++;
         total++;
         if (gap) $display("FAIL %s throughput: got bubble expected none", tag);
         else passed++;
      end
      e = exp_q.pop_front();
      last_exp = e;
      total++;
      if (sum_abs_err !== e.sum) $display("FAIL %s sum: got %0d expected %0d", tag, sum_abs_err, e.sum);
      else passed++;
      total++;
      if (max_abs_err !== e.mx) $display("FAIL %s max: got %0d expected %0d", tag, max_abs_err, e.mx);
      else passed++;
      total++;
      if (err_count !== e.cnt) $display("FAIL %s err_count: got %0d expected %0d", tag, err_count, e.cnt);
      else passed++;
      total++;
      if (sum8 !== e.sum8 || max8 !== e.mx || cnt8 !== e.cnt || out_valid8 !== 1'b1)
         $display("FAIL %s acc8: got sum=%0d max=%0d cnt=%0d v=%b expected sum=%0d max=%0d cnt=%0d v=1",
                  tag, sum8, max8, cnt8, out_valid8, e.sum8, e.mx, e.cnt);
      else passed++;
   endtask

   // Take the statistics and check the block returns to idle with results held.
   task automatic release_window(input string tag);
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || busy8 !== 1'b0)
         $display("FAIL %s release: got v=%b busy=%b busy8=%b expected 0 0 0", tag, out_valid, busy, busy8);
      else passed++;
      total++;
      if (sum_abs_err !== last_exp.sum || max_abs_err !== last_exp.mx || err_count !== last_exp.cnt)
         $display("FAIL %s held_stats: got %0d/%0d/%0d expected %0d/%0d/%0d", tag,
                  sum_abs_err, max_abs_err, err_count, last_exp.sum, last_exp.mx, last_exp.cnt);
      else passed++;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick;
      tick;
      total++;
      if (in_ready !== 1'b0) $display("FAIL reset in_ready: got %b expected 0", in_ready); else passed++;
      total++;
      if (out_valid !== 1'b0) $display("FAIL reset out_valid: got %b expected 0", out_valid); else passed++;
      total++;
      if (busy !== 1'b0) $display("FAIL reset busy: got %b expected 0", busy); else passed++;
      total++;
      if (sum_abs_err !== 40'd0) $display("FAIL reset sum: got %0d expected 0", sum_abs_err); else passed++;
      total++;
      if (max_abs_err !== 16'd0) $display("FAIL reset max: got %0d expected 0", max_abs_err); else passed++;
      total++;
      if (err_count !== 16'd0) $display("FAIL reset err_count: got %0d expected 0", err_count); else passed++;
      rst = 1'b0;
      tick;
   endtask

   task automatic test_no_error;
      clear_beats();
      for (int i = 0; i < 4; i++) add_beat(8'd15, 8'd15, 16'd225);
      run_window(4, 4, "no_error");
      release_window("no_error");
   endtask

   task automatic test_mixed_errors;
      clear_beats();
      add_beat(8'd255, 8'd255, 16'd65000);
      add_beat(8'd16, 8'd16, 16'd300);
      add_beat(8'd3, 8'd5, 16'd15);
      run_window(3, 3, "mixed");
      release_window("mixed");
   endtask

   task automatic test_back_to_back;
      clear_beats();
      for (int i = 0; i < 5; i++) add_beat(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)));
      run_window(2, 5, "back_to_back");
      release_window("back_to_back");
   endtask

   task automatic test_zero_window;
      clear_beats();
      run_window(0, 0, "zero");
      release_window("zero");
   endtask

   task automatic test_saturation;
      clear_beats();
      add_beat(8'd0, 8'd0, 16'd200);
      add_beat(8'd0, 8'd0, 16'd200);
      run_window(2, 2, "saturation");
      for (int i = 0; i < 10; i++) begin
         start = (i % 2 == 0);
         num_samples = 16'd5;
         tick;
         total++;
         if (out_valid8 !== 1'b1 || busy8 !== 1'b1 || sum8 !== 8'd255 || max8 !== 16'd200 || cnt8 !== 16'd2)
            $display("FAIL hold8 cycle %0d: got v=%b busy=%b sum=%0d max=%0d cnt=%0d expected 1 1 255 200 2",
                     i, out_valid8, busy8, sum8, max8, cnt8);
         else passed++;
         total++;
         if (out_valid !== 1'b1 || sum_abs_err !== 40'd400 || in_ready !== 1'b0)
            $display("FAIL hold cycle %0d: got v=%b sum=%0d rdy=%b expected 1 400 0", i, out_valid, sum_abs_err, in_ready);
         else passed++;
      end
      start = 1'b0;
      num_samples = 16'd0;
      release_window("saturation");
   endtask

   task automatic test_reset_mid_run;
      num_samples = 16'd4;
      start = 1'b1;
      tick;
      start = 1'b0;
      in_valid = 1'b1;
      in_a = 8'd10;
      in_b = 8'd10;
      in_r = 16'd0;
      tick;
      in_valid = 1'b0;
      tick;
      tick;
      rst = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL mid_reset flags: got rdy=%b v=%b busy=%b expected 0 0 0", in_ready, out_valid, busy);
      else passed++;
      total++;
      if (sum_abs_err !== 40'd0 || max_abs_err !== 16'd0 || err_count !== 16'd0 || sum8 !== 8'd0)
         $display("FAIL mid_reset stats: got %0d/%0d/%0d expected 0/0/0", sum_abs_err, max_abs_err, err_count);
      else passed++;
      tick;
      rst = 1'b0;
      tick;
      clear_beats();
      add_beat(8'd2, 8'd3, 16'd7);
      run_window(1, 1, "after_reset");
      release_window("after_reset");
   endtask

   task automatic test_random;
      int n;
      for (int w = 0; w < 4; w++) begin
         n = $urandom_range(1, 8);
         clear_beats();
         for (int i = 0; i < n + 3; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 2) == 0) add_beat(a, b, 16'(a) * 16'(b));
            else add_beat(a, b, 16'($urandom_range(0, 65535)));
         end
         run_window(n, n + 1, "random");
         release_window("random");
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      num_samples = 16'd0;
      in_valid = 1'b0;
      in_a = 8'd0;
      in_b = 8'd0;
      in_r = 16'd0;
      out_ready = 1'b0;
      test_reset();
      test_no_error();
      test_mixed_errors();
      test_back_to_back();
      test_zero_window();
      test_saturation();
      test_reset_mid_run();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
